// File: rtl/kuuga_axil_sim_mem.sv
`default_nettype none
// ============================================================================
// Module      : kuuga_axil_sim_mem
// Description : AXI4-Lite slave memory for simulation wrappers. Fills itself
//               after reset, adds fixed read/write response latency, returns
//               SLVERR outside its address window, offers a registered
//               backdoor port and saturating transaction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module kuuga_axil_sim_mem #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 20000,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          RD_LATENCY  = 2,
    parameter int          WR_LATENCY  = 1,
    parameter int          FILL_MODE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic                    bd_we,
    input  logic                    bd_re,
    input  logic [ADDR_WIDTH-1:0]   bd_addr,
    input  logic [DATA_WIDTH-1:0]   bd_wdata,
    input  logic [DATA_WIDTH/8-1:0] bd_strb,
    output logic [DATA_WIDTH-1:0]   bd_rdata,
    output logic                    bd_rvalid,
    output logic                    init_busy,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count,
    output logic [31:0]             err_count
);

    localparam int                    c_BYTES      = DATA_WIDTH / 8;
    localparam int                    c_BYTE_SHIFT = $clog2(c_BYTES);
    localparam int                    c_IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_BASE       = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH      = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX   = c_IDX_W'(DEPTH_WORDS - 1);
    localparam logic [3:0]            c_RD_LAT_M1  = 4'(RD_LATENCY - 1);
    localparam logic [3:0]            c_WR_LAT_M1  = 4'(WR_LATENCY - 1);
    localparam logic [31:0]           c_LFSR_SEED  = 32'hACE1_ACE1;
    localparam logic [1:0]            c_RESP_OKAY  = 2'b00;
    localparam logic [1:0]            c_RESP_SLVERR = 2'b10;

    localparam logic [2:0] c_ST_INIT    = 3'd0;
    localparam logic [2:0] c_ST_IDLE    = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_RD_RESP = 3'd3;
    localparam logic [2:0] c_ST_WR_WAIT = 3'd4;
    localparam logic [2:0] c_ST_WR_RESP = 3'd5;

    // Word index of a byte address (low byte-lane bits dropped).
    function automatic logic [c_IDX_W-1:0] f_word(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] v_off;
        v_off = (a - c_BASE) >> c_BYTE_SHIFT;
        return v_off[c_IDX_W-1:0];
    endfunction

    // True when the address falls inside the stored window.
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] v_off;
        v_off = (a - c_BASE) >> c_BYTE_SHIFT;
        return (a >= c_BASE) && (v_off < c_DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_init_idx;
    logic [31:0]           r_lfsr;
    logic [3:0]            r_lat;
    logic                  r_last_rd;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_bd_rdata;
    logic                  r_bd_rvalid;
    logic [31:0]           r_rd_count;
    logic [31:0]           r_wr_count;
    logic [31:0]           r_err_count;

    logic                  w_wr_pend;
    logic                  w_grant_wr;
    logic                  w_arready;
    logic                  w_rd_hs;
    logic                  w_wr_hs;
    logic                  w_r_done;
    logic                  w_b_done;
    logic                  w_ar_ok;
    logic                  w_aw_ok;
    logic                  w_bd_ok;
    logic                  w_active;
    logic [c_IDX_W-1:0]    w_ar_idx;
    logic [c_IDX_W-1:0]    w_aw_idx;
    logic [c_IDX_W-1:0]    w_bd_idx;
    logic [DATA_WIDTH-1:0] w_fill;

    assign w_active  = (r_state != c_ST_INIT);
    assign w_ar_ok   = f_in_range(s_araddr);
    assign w_aw_ok   = f_in_range(s_awaddr);
    assign w_bd_ok   = f_in_range(bd_addr);
    assign w_ar_idx  = f_word(s_araddr);
    assign w_aw_idx  = f_word(s_awaddr);
    assign w_bd_idx  = f_word(bd_addr);

    // Arbitration: a write needs both AW and W; on contention the grant flips
    // relative to the previous grant, and r_last_rd resets low so read wins first.
    always_comb begin
        w_wr_pend  = s_awvalid && s_wvalid;
        w_grant_wr = (r_state == c_ST_IDLE) && w_wr_pend && (!s_arvalid || r_last_rd);
        w_arready  = (r_state == c_ST_IDLE) && !w_grant_wr;
        w_rd_hs    = w_arready && s_arvalid;
        w_wr_hs    = w_grant_wr;
        w_r_done   = (r_state == c_ST_RD_RESP) && s_rready;
        w_b_done   = (r_state == c_ST_WR_RESP) && s_bready;
    end

    // Fill value for the word currently being initialised.
    always_comb begin
        w_fill = '0;
        case (FILL_MODE)
            0:       w_fill = '0;
            1:       w_fill = DATA_WIDTH'(r_init_idx);
            default: w_fill = {(DATA_WIDTH/32){r_lfsr}};
        endcase
    end

    // Next-state logic; a latency of 1 skips the wait state entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT:    if (r_init_idx == c_LAST_IDX) w_state_nxt = c_ST_IDLE;
            c_ST_IDLE: begin
                if (w_wr_hs)
                    w_state_nxt = (WR_LATENCY <= 1) ? c_ST_WR_RESP : c_ST_WR_WAIT;
                else if (w_rd_hs)
                    w_state_nxt = (RD_LATENCY <= 1) ? c_ST_RD_RESP : c_ST_RD_WAIT;
            end
            c_ST_RD_WAIT: if (r_lat <= 4'd1) w_state_nxt = c_ST_RD_RESP;
            c_ST_RD_RESP: if (s_rready) w_state_nxt = c_ST_IDLE;
            c_ST_WR_WAIT: if (r_lat <= 4'd1) w_state_nxt = c_ST_WR_RESP;
            c_ST_WR_RESP: if (s_bready) w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_INIT;
        endcase
    end

    // Control state, response registers, backdoor read port and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_INIT;
            r_init_idx  <= '0;
            r_lfsr      <= c_LFSR_SEED;
            r_lat       <= '0;
            r_last_rd   <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= c_RESP_OKAY;
            r_bresp     <= c_RESP_OKAY;
            r_bd_rdata  <= '0;
            r_bd_rvalid <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_INIT) begin
                r_init_idx <= r_init_idx + 1'b1;
                r_lfsr     <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
            end
            if (w_wr_hs) begin
                r_last_rd <= 1'b0;
                r_lat     <= c_WR_LAT_M1;
                r_bresp   <= w_aw_ok ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if (w_rd_hs) begin
                r_last_rd <= 1'b1;
                r_lat     <= c_RD_LAT_M1;
                r_rdata   <= w_ar_ok ? r_mem[w_ar_idx] : '0;
                r_rresp   <= w_ar_ok ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if (r_state == c_ST_RD_WAIT || r_state == c_ST_WR_WAIT) begin
                r_lat <= r_lat - 1'b1;
            end
            r_bd_rvalid <= bd_re && w_active;
            if (bd_re && w_active)
                r_bd_rdata <= w_bd_ok ? r_mem[w_bd_idx] : '0;
            if (w_r_done && r_rd_count != 32'hFFFF_FFFF)
                r_rd_count <= r_rd_count + 1'b1;
            if (w_b_done && r_wr_count != 32'hFFFF_FFFF)
                r_wr_count <= r_wr_count + 1'b1;
            if (((w_r_done && r_rresp == c_RESP_SLVERR) || (w_b_done && r_bresp == c_RESP_SLVERR))
                && r_err_count != 32'hFFFF_FFFF)
                r_err_count <= r_err_count + 1'b1;
        end
    end

    // Storage: fill sweep, then AXI writes with backdoor bytes landing last so
    // the backdoor wins any byte both sides touch in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_ST_INIT) begin
                r_mem[r_init_idx] <= w_fill;
            end else begin
                if (w_wr_hs && w_aw_ok) begin
                    for (int b = 0; b < c_BYTES; b++)
                        if (s_wstrb[b]) r_mem[w_aw_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
                end
                if (bd_we && w_bd_ok) begin
                    for (int b = 0; b < c_BYTES; b++)
                        if (bd_strb[b]) r_mem[w_bd_idx][b*8 +: 8] <= bd_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_arready = w_arready;
    assign s_awready = w_grant_wr;
    assign s_wready  = w_grant_wr;
    assign s_rvalid  = (r_state == c_ST_RD_RESP);
    assign s_bvalid  = (r_state == c_ST_WR_RESP);
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_bresp   = r_bresp;
    assign bd_rdata  = r_bd_rdata;
    assign bd_rvalid = r_bd_rvalid;
    assign init_busy = (r_state == c_ST_INIT);
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
